// File: rtl/mp_add_pkg.sv
// Shared types and sizing helpers for the multi-precision add scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mp_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Index widths never collapse to zero bits, even for a single limb.
    function automatic int idw(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 64;
    localparam int DEF_LIMBS   = 4;
    localparam int DEF_IDW     = idw(DEF_NUM_REQ);
    localparam int DEF_OPW     = DEF_WIDTH * DEF_LIMBS;

endpackage

// File: rtl/mp_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; caller masks req when it cannot accept.
module mp_rr_pick
    import mp_add_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        // Scan farthest-first so the nearest valid requester overwrites last.
        for (int off = N; off >= 1; off--) begin
            int k;
            k = (int'(ptr) + off) % N;
            if (req[k]) begin
                gnt = N'(1) << k;
                idx = IW'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mp_add_scheduler.sv
// Time-shares one WIDTH-bit limb adder among NUM_REQ multi-precision add/sub requesters.
// Latency: res_valid rises LIMBS cycles after the accept edge; issue interval LIMBS+2.
// Backpressure: req_ready only in IDLE; result held stable in DONE until res_ready.
module mp_add_scheduler
    import mp_add_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 64,
    parameter  int LIMBS   = 4,
    localparam int OPW     = WIDTH * LIMBS,
    localparam int IDW     = idw(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OPW-1:0] req_a,
    input  logic [NUM_REQ*OPW-1:0] req_b,
    input  logic [NUM_REQ-1:0]     req_cin,
    input  logic [NUM_REQ-1:0]     req_sub,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [OPW-1:0]         res_sum,
    output logic                   res_cout,
    output logic [IDW-1:0]         res_id,
    output logic                   busy
);

    localparam int LCW = idw(LIMBS);

    state_t           state_q, state_d;
    logic [OPW-1:0]   a_q, a_d;
    logic [OPW-1:0]   b_q, b_d;
    logic [OPW-1:0]   sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [LCW-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;

    logic [OPW-1:0]   a_sel, b_sel;
    logic [WIDTH-1:0] a_limb, b_limb;
    logic [WIDTH:0]   limb_sum;

    assign pick_req = req_valid & {NUM_REQ{state_q == ST_IDLE}};

    mp_rr_pick #(
        .N  (NUM_REQ),
        .IW (IDW)
    ) u_pick (
        .req (pick_req),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign req_ready = pick_gnt;

    assign a_sel  = req_a[int'(pick_idx) * OPW +: OPW];
    assign b_sel  = req_b[int'(pick_idx) * OPW +: OPW];
    assign a_limb = a_q[int'(cnt_q) * WIDTH +: WIDTH];
    assign b_limb = b_q[int'(cnt_q) * WIDTH +: WIDTH];

    // Carry between limbs travels only through carry_q.
    assign limb_sum = {1'b0, a_limb} + {1'b0, b_limb} + {{WIDTH{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    // Subtract as A + ~B + 1.
                    a_d     = a_sel;
                    b_d     = req_sub[pick_idx] ? ~b_sel : b_sel;
                    carry_d = req_sub[pick_idx] ? 1'b1 : req_cin[pick_idx];
                    id_d    = pick_idx;
                    rr_d    = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_d[int'(cnt_q) * WIDTH +: WIDTH] = limb_sum[WIDTH-1:0];
                carry_d = limb_sum[WIDTH];
                if (cnt_q == LCW'(LIMBS - 1)) begin
                    cout_d  = limb_sum[WIDTH];
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= '0;
            rr_q    <= IDW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign res_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;

endmodule
